// File: rtl/wb_spi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_spi_ctrl
// Brief    : Wishbone slave that issues SPI command words, collects replies and
//            exposes a read window onto the shared RX buffer RAM. The optional
//            busy timeout is built when WB_SPI_CTRL_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module wb_spi_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [31:0] CMD_IDLE       = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [8:0]  ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic [31:0] cmd_out,
    input  logic        spi_ack_in,
    input  logic [31:0] spi_data_in,
    output logic [7:0]  buf_addra,
    input  logic [31:0] buf_douta
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUFRD = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit in 16 bits and be nonzero");
    end

    state_t      r_state, w_state_nxt;
    logic        r_is_buf;
    logic [31:0] r_dat, r_last_cmd, r_rxdata, r_cmd_out;
    logic [7:0]  r_buf_addr;
    logic        r_busy, r_done, r_err;

    logic        w_accept, w_cmd_wr, w_stat_rd, w_complete, w_free;
    logic        w_cmd_ok, w_cmd_bad, w_tmo_fire, w_tmo_bit;
    logic [31:0] w_status, w_rd_data;

    assign w_accept   = (r_state == S_IDLE) && CYC_I && STB_I;
    assign w_cmd_wr   = w_accept && WE_I && !ADR_I[8] && (ADR_I[7:0] == 8'h00);
    assign w_stat_rd  = w_accept && !WE_I && !ADR_I[8] && (ADR_I[7:0] == 8'h01);
    assign w_complete = spi_ack_in && r_busy;
    // A finishing transfer frees the engine in the same cycle a new command lands.
    assign w_free     = !r_busy || w_complete || w_tmo_fire;
    assign w_cmd_ok   = w_cmd_wr && w_free && (DAT_I != CMD_IDLE);
    assign w_cmd_bad  = w_cmd_wr && !w_cmd_ok;
    assign w_status   = {28'd0, w_tmo_bit, r_err, r_done, r_busy};

    always_comb begin
        w_rd_data = 32'd0;
        if (!ADR_I[8]) begin
            case (ADR_I[7:0])
                8'h00:   w_rd_data = r_last_cmd;
                8'h01:   w_rd_data = w_status;
                8'h02:   w_rd_data = r_rxdata;
                default: w_rd_data = 32'd0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (ADR_I[8] && !WE_I) ? S_BUFRD : S_ACK;
            S_BUFRD: w_state_nxt = CYC_I ? S_ACK : S_IDLE;
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_is_buf   <= 1'b0;
            r_dat      <= 32'd0;
            r_buf_addr <= 8'd0;
            r_last_cmd <= 32'd0;
            r_rxdata   <= 32'd0;
            r_cmd_out  <= CMD_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_is_buf <= ADR_I[8] && !WE_I;
                r_dat    <= WE_I ? 32'd0 : w_rd_data;
            end
            if (w_accept && ADR_I[8] && !WE_I) begin
                r_buf_addr <= ADR_I[7:0];
            end
            if (w_cmd_ok) begin
                r_cmd_out  <= DAT_I;
                r_last_cmd <= DAT_I;
                r_busy     <= 1'b1;
            end else if (w_complete || w_tmo_fire) begin
                r_cmd_out <= CMD_IDLE;
                r_busy    <= 1'b0;
            end
            if (w_complete) begin
                r_rxdata <= spi_data_in;
            end
            if (w_complete)     r_done <= 1'b1;
            else if (w_stat_rd) r_done <= 1'b0;
            if (w_cmd_bad)      r_err  <= 1'b1;
            else if (w_stat_rd) r_err  <= 1'b0;
        end
    end

`ifdef WB_SPI_CTRL_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_tmo_cnt;
    logic        r_timeout;

    // A completion arriving on the final count takes precedence over the abort.
    assign w_tmo_fire = r_busy && !spi_ack_in && (r_tmo_cnt == c_TMO_LAST);
    assign w_tmo_bit  = r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            if (w_cmd_ok || w_complete || w_tmo_fire) r_tmo_cnt <= 16'd0;
            else if (r_busy)                          r_tmo_cnt <= r_tmo_cnt + 16'd1;
            if (w_tmo_fire)     r_timeout <= 1'b1;
            else if (w_stat_rd) r_timeout <= 1'b0;
        end
    end
`else
    assign w_tmo_fire = 1'b0;
    assign w_tmo_bit  = 1'b0;
`endif

    assign ACK_O     = (r_state == S_ACK);
    assign DAT_O     = ACK_O ? (r_is_buf ? buf_douta : r_dat) : 32'd0;
    assign cmd_out   = r_cmd_out;
    assign buf_addra = r_buf_addr;

endmodule
`default_nettype wire
